// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - cpu/ext request ports, DM drive and status bundle for dm_arbiter
// Optional statistics outputs appear only when DM_ARB_STATS_EN is defined.
interface dm_arbiter_if
`ifdef DM_ARB_STATS_EN
  #(parameter int CNT_W = 16)
`endif
  ;
  logic        cpu_req;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [2:0]  cpu_op;
  logic [31:0] cpu_rd;
  logic        cpu_done;
  logic        cpu_stall;

  logic        ext_req;
  logic        ext_wr;
  logic [31:0] ext_addr;
  logic [31:0] ext_wd;
  logic [2:0]  ext_op;
  logic [31:0] ext_rd;
  logic        ext_done;

  logic [31:0] dm_A;
  logic [31:0] dm_WD;
  logic [2:0]  dm_op;
  logic        dm_wr;
  logic [31:0] dm_rdata;
  logic        misalign;

`ifdef DM_ARB_STATS_EN
  logic [CNT_W-1:0] stat_cpu_acc;
  logic [CNT_W-1:0] stat_ext_acc;
  logic [CNT_W-1:0] stat_conflict;
`endif

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wd, cpu_op,
    output cpu_rd, cpu_done, cpu_stall,
    input  ext_req, ext_wr, ext_addr, ext_wd, ext_op,
    output ext_rd, ext_done,
    output dm_A, dm_WD, dm_op, dm_wr, misalign,
    input  dm_rdata
`ifdef DM_ARB_STATS_EN
    , output stat_cpu_acc, stat_ext_acc, stat_conflict
`endif
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wd, cpu_op,
    input  cpu_rd, cpu_done, cpu_stall,
    output ext_req, ext_wr, ext_addr, ext_wd, ext_op,
    input  ext_rd, ext_done,
    input  dm_A, dm_WD, dm_op, dm_wr, misalign,
    output dm_rdata
`ifdef DM_ARB_STATS_EN
    , input stat_cpu_acc, stat_ext_acc, stat_conflict
`endif
  );
endinterface

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - round-robin cpu/ext arbiter for the single-port data memory
// Optional DM_ARB_STATS_EN adds saturating access/conflict counters.
module dm_arbiter #(
  parameter int LAT = 1
`ifdef DM_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  dm_arbiter_if.slave   io_bus
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY_CPU, S_BUSY_EXT} state_t;

  localparam logic [3:0] C_LAST = 4'(LAT - 1);
  localparam logic [2:0] OP_W  = 3'd0;
  localparam logic [2:0] OP_H  = 3'd1;
  localparam logic [2:0] OP_HU = 3'd2;
  localparam logic [2:0] OP_B  = 3'd3;
  localparam logic [2:0] OP_BU = 3'd4;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_last_cpu;
  logic        r_wr;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic [2:0]  r_op;

  logic        w_idle, w_gnt_cpu, w_gnt_ext, w_sel_cpu, w_active, w_final;
  logic        w_wr, w_known, w_aligned, w_ok;
  logic [31:0] w_addr, w_wd, w_rdv;
  logic [2:0]  w_op;

  // The grant cycle is access cycle 0, so the bus is fed straight from the winner
  // while idle and from the latched copy afterwards.
  always_comb begin
    w_idle    = (r_state == S_IDLE);
    w_gnt_cpu = w_idle & io_bus.cpu_req & (~io_bus.ext_req | ~r_last_cpu);
    w_gnt_ext = w_idle & io_bus.ext_req & ~w_gnt_cpu;
    w_sel_cpu = w_idle ? w_gnt_cpu : (r_state == S_BUSY_CPU);
    w_active  = i_rst_n & (w_idle ? (w_gnt_cpu | w_gnt_ext) : 1'b1);
    if (!w_idle) begin
      w_wr = r_wr;  w_addr = r_addr;  w_wd = r_wd;  w_op = r_op;
    end else if (w_gnt_cpu) begin
      w_wr = io_bus.cpu_wr;  w_addr = io_bus.cpu_addr;
      w_wd = io_bus.cpu_wd;  w_op   = io_bus.cpu_op;
    end else begin
      w_wr = io_bus.ext_wr;  w_addr = io_bus.ext_addr;
      w_wd = io_bus.ext_wd;  w_op   = io_bus.ext_op;
    end
    w_final = w_active & (w_idle ? (C_LAST == 4'd0) : (r_cnt == C_LAST));

    w_known   = 1'b1;
    w_aligned = 1'b1;
    case (w_op)
      OP_W:         w_aligned = (w_addr[1:0] == 2'b00);
      OP_H, OP_HU:  w_aligned = ~w_addr[0];
      OP_B, OP_BU:  w_aligned = 1'b1;
      default:      w_known   = 1'b0;
    endcase
    w_ok  = w_known & w_aligned;
    w_rdv = (w_final & ~w_wr & w_ok) ? io_bus.dm_rdata : 32'd0;
  end

  assign io_bus.dm_A      = w_active ? w_addr : 32'd0;
  assign io_bus.dm_WD     = w_active ? w_wd   : 32'd0;
  assign io_bus.dm_op     = w_active ? w_op   : 3'd0;
  assign io_bus.dm_wr     = w_final & w_wr & w_ok;
  assign io_bus.misalign  = w_final & w_known & ~w_aligned;
  assign io_bus.cpu_done  = w_final & w_sel_cpu;
  assign io_bus.ext_done  = w_final & ~w_sel_cpu;
  assign io_bus.cpu_rd    = w_sel_cpu ? w_rdv : 32'd0;
  assign io_bus.ext_rd    = w_sel_cpu ? 32'd0 : w_rdv;
  assign io_bus.cpu_stall = io_bus.cpu_req & ~io_bus.cpu_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_last_cpu <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= 32'd0;
      r_wd       <= 32'd0;
      r_op       <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_cpu | w_gnt_ext) begin
            r_last_cpu <= w_gnt_cpu;
            r_wr       <= w_wr;
            r_addr     <= w_addr;
            r_wd       <= w_wd;
            r_op       <= w_op;
            if (C_LAST != 4'd0) begin
              r_state <= w_gnt_cpu ? S_BUSY_CPU : S_BUSY_EXT;
              r_cnt   <= 4'd1;
            end
          end
        end
        default: begin
          if (r_cnt == C_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
      endcase
    end
  end

`ifdef DM_ARB_STATS_EN
  logic [CNT_W-1:0] r_stat_cpu, r_stat_ext, r_stat_conf;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stat_cpu  <= '0;
      r_stat_ext  <= '0;
      r_stat_conf <= '0;
    end else begin
      if (io_bus.cpu_done && !(&r_stat_cpu))
        r_stat_cpu <= r_stat_cpu + 1'b1;
      if (io_bus.ext_done && !(&r_stat_ext))
        r_stat_ext <= r_stat_ext + 1'b1;
      // Only one side is ever served per cycle, so both requesting means one waits.
      if (io_bus.cpu_req && io_bus.ext_req && !(&r_stat_conf))
        r_stat_conf <= r_stat_conf + 1'b1;
    end
  end

  assign io_bus.stat_cpu_acc  = r_stat_cpu;
  assign io_bus.stat_ext_acc  = r_stat_ext;
  assign io_bus.stat_conflict = r_stat_conf;
`endif
endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed vector bench for dm_arbiter at LAT=1 and LAT=3
// Each DUT drives its own behavioural data memory.
module tb_dm_arbiter;
  localparam logic [2:0] OP_W = 3'd0, OP_H = 3'd1, OP_HU = 3'd2, OP_B = 3'd3, OP_BU = 3'd4;

  logic clk = 1'b0;
  logic rst1_n, rst3_n;
  int   n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  dm_arbiter_if b1 ();
  dm_arbiter_if b3 ();

  dm_arbiter #(.LAT(1)) u1 (.i_clk(clk), .i_rst_n(rst1_n), .io_bus(b1));
  dm_arbiter #(.LAT(3)) u3 (.i_clk(clk), .i_rst_n(rst3_n), .io_bus(b3));

  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];

  function automatic logic [31:0] dm_read(input logic [31:0] w, input logic [1:0] a, input logic [2:0] op);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? w[31:16] : w[15:0];
    b = w[8*a +: 8];
    case (op)
      OP_W:    return w;
      OP_H:    return {{16{h[15]}}, h};
      OP_HU:   return {16'd0, h};
      OP_B:    return {{24{b[7]}}, b};
      OP_BU:   return {24'd0, b};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] dm_write(input logic [31:0] w, input logic [1:0] a, input logic [2:0] op,
                                           input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (op)
      OP_W:        r = d;
      OP_H, OP_HU: if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      OP_B, OP_BU: r[8*a +: 8] = d[7:0];
      default:     r = w;
    endcase
    return r;
  endfunction

  always_comb b1.dm_rdata = dm_read(mem1[b1.dm_A[7:2]], b1.dm_A[1:0], b1.dm_op);
  always_comb b3.dm_rdata = dm_read(mem3[b3.dm_A[7:2]], b3.dm_A[1:0], b3.dm_op);

  always @(posedge clk) begin
    if (b1.dm_wr) mem1[b1.dm_A[7:2]] <= dm_write(mem1[b1.dm_A[7:2]], b1.dm_A[1:0], b1.dm_op, b1.dm_WD);
    if (b3.dm_wr) mem3[b3.dm_A[7:2]] <= dm_write(mem3[b3.dm_A[7:2]], b3.dm_A[1:0], b3.dm_op, b3.dm_WD);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cwd;
    logic [2:0]  cop;
    logic        er, ew;
    logic [31:0] ea, ewd;
    logic [2:0]  eop;
    logic        x_cdone, x_stall, x_edone, x_dmwr, x_mis;
    logic [31:0] x_crd, x_erd;
  } vec_t;

  typedef struct {
    logic        cd, st, ed, wr;
    logic [31:0] a;
  } cyc_t;

  vec_t vec [19];
  cyc_t t2 [7];
  int   got_side [8];
  int   n_got;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem1[i] = 32'd0;
      mem3[i] = 32'd0;
    end
    rst1_n = 1'b0;  rst3_n = 1'b0;
    {b1.cpu_req, b1.cpu_wr, b1.cpu_addr, b1.cpu_wd, b1.cpu_op} = '0;
    {b1.ext_req, b1.ext_wr, b1.ext_addr, b1.ext_wd, b1.ext_op} = '0;
    {b3.cpu_req, b3.cpu_wr, b3.cpu_addr, b3.cpu_wd, b3.cpu_op} = '0;
    {b3.ext_req, b3.ext_wr, b3.ext_addr, b3.ext_wd, b3.ext_op} = '0;

    //                cr cw ca      cwd           cop   er ew ea     ewd           eop    cd st ed wr mi crd           erd
    vec[0]  = '{0, 0, 32'h00, 32'h0,        OP_W,  0, 0, 32'h0,  32'h0,        OP_W,  0, 0, 0, 0, 0, 32'h0,        32'h0};
    vec[1]  = '{1, 1, 32'h10, 32'h12345678, OP_W,  0, 0, 32'h0,  32'h0,        OP_W,  1, 0, 0, 1, 0, 32'h0,        32'h0};
    vec[2]  = '{1, 0, 32'h10, 32'h0,        OP_W,  0, 0, 32'h0,  32'h0,        OP_W,  1, 0, 0, 0, 0, 32'h12345678, 32'h0};
    vec[3]  = '{0, 0, 32'h00, 32'h0,        OP_W,  1, 1, 32'h2,  32'hAB,       OP_B,  0, 0, 1, 1, 0, 32'h0,        32'h0};
    vec[4]  = '{1, 0, 32'h02, 32'h0,        OP_BU, 0, 0, 32'h0,  32'h0,        OP_W,  1, 0, 0, 0, 0, 32'h000000AB, 32'h0};
    vec[5]  = '{1, 0, 32'h02, 32'h0,        OP_B,  0, 0, 32'h0,  32'h0,        OP_W,  1, 0, 0, 0, 0, 32'hFFFFFFAB, 32'h0};
    vec[6]  = '{1, 1, 32'h13, 32'hDEAD,     OP_H,  0, 0, 32'h0,  32'h0,        OP_W,  1, 0, 0, 0, 1, 32'h0,        32'h0};
    vec[7]  = '{1, 0, 32'h10, 32'h0,        OP_W,  0, 0, 32'h0,  32'h0,        OP_W,  1, 0, 0, 0, 0, 32'h12345678, 32'h0};
    vec[8]  = '{1, 0, 32'h10, 32'h0,        OP_W,  1, 0, 32'h0,  32'h0,        OP_W,  0, 1, 1, 0, 0, 32'h0,        32'h00AB0000};
    vec[9]  = '{1, 0, 32'h10, 32'h0,        OP_W,  1, 0, 32'h0,  32'h0,        OP_W,  1, 0, 0, 0, 0, 32'h12345678, 32'h0};
    vec[10] = '{1, 0, 32'h10, 32'h0,        OP_W,  1, 0, 32'h0,  32'h0,        OP_W,  0, 1, 1, 0, 0, 32'h0,        32'h00AB0000};
    vec[11] = '{1, 1, 32'h10, 32'hFFFFFFFF, 3'd7,  0, 0, 32'h0,  32'h0,        OP_W,  1, 0, 0, 0, 0, 32'h0,        32'h0};
    vec[12] = '{1, 0, 32'h12, 32'h0,        OP_H,  0, 0, 32'h0,  32'h0,        OP_W,  1, 0, 0, 0, 0, 32'h00001234, 32'h0};
    vec[13] = '{1, 0, 32'h10, 32'h0,        OP_HU, 0, 0, 32'h0,  32'h0,        OP_W,  1, 0, 0, 0, 0, 32'h00005678, 32'h0};
    vec[14] = '{1, 0, 32'h03, 32'h0,        OP_W,  0, 0, 32'h0,  32'h0,        OP_W,  1, 0, 0, 0, 1, 32'h0,        32'h0};
    vec[15] = '{0, 0, 32'h00, 32'h0,        OP_W,  1, 1, 32'h20, 32'hCAFEF00D, OP_W,  0, 0, 1, 1, 0, 32'h0,        32'h0};
    vec[16] = '{1, 0, 32'h20, 32'h0,        OP_H,  0, 0, 32'h0,  32'h0,        OP_W,  1, 0, 0, 0, 0, 32'hFFFFF00D, 32'h0};
    vec[17] = '{1, 0, 32'h20, 32'h0,        OP_W,  0, 0, 32'h0,  32'h0,        OP_W,  1, 0, 0, 0, 0, 32'hCAFEF00D, 32'h0};
    vec[18] = '{1, 0, 32'h10, 32'h0,        3'd5,  0, 0, 32'h0,  32'h0,        OP_W,  1, 0, 0, 0, 0, 32'h0,        32'h0};

    t2[0] = '{0, 1, 0, 0, 32'h40};
    t2[1] = '{0, 1, 0, 0, 32'h40};
    t2[2] = '{1, 0, 0, 1, 32'h40};
    t2[3] = '{0, 0, 0, 0, 32'h44};
    t2[4] = '{0, 0, 0, 0, 32'h44};
    t2[5] = '{0, 0, 1, 1, 32'h44};
    t2[6] = '{0, 0, 0, 0, 32'h00};

    // reset state
    @(negedge clk);
    chk("rst_cpu_done", 32'(b1.cpu_done), 32'd0);
    chk("rst_dm_A", b1.dm_A, 32'd0);
    chk("rst_dm_wr", 32'(b3.dm_wr), 32'd0);
    next_cycle();
    rst1_n = 1'b1;  rst3_n = 1'b1;

    // LAT=1 table
    for (int i = 0; i < 19; i++) begin
      b1.cpu_req = vec[i].cr;  b1.cpu_wr = vec[i].cw;  b1.cpu_addr = vec[i].ca;
      b1.cpu_wd  = vec[i].cwd; b1.cpu_op = vec[i].cop;
      b1.ext_req = vec[i].er;  b1.ext_wr = vec[i].ew;  b1.ext_addr = vec[i].ea;
      b1.ext_wd  = vec[i].ewd; b1.ext_op = vec[i].eop;
      @(negedge clk);
      chk($sformatf("v%0d_cpu_done", i), 32'(b1.cpu_done), 32'(vec[i].x_cdone));
      chk($sformatf("v%0d_cpu_stall", i), 32'(b1.cpu_stall), 32'(vec[i].x_stall));
      chk($sformatf("v%0d_ext_done", i), 32'(b1.ext_done), 32'(vec[i].x_edone));
      chk($sformatf("v%0d_dm_wr", i), 32'(b1.dm_wr), 32'(vec[i].x_dmwr));
      chk($sformatf("v%0d_misalign", i), 32'(b1.misalign), 32'(vec[i].x_mis));
      chk($sformatf("v%0d_cpu_rd", i), b1.cpu_rd, vec[i].x_crd);
      chk($sformatf("v%0d_ext_rd", i), b1.ext_rd, vec[i].x_erd);
      next_cycle();
    end
    b1.cpu_req = 1'b0;  b1.ext_req = 1'b0;
    @(negedge clk);
    chk("t1_idle_dm_A", b1.dm_A, 32'd0);
    chk("t4_mem_unchanged", mem1[4], 32'h12345678);
`ifdef DM_ARB_STATS_EN
    chk("stat_cpu_acc", 32'(b1.stat_cpu_acc), 32'd14);
    chk("stat_ext_acc", 32'(b1.stat_ext_acc), 32'd4);
    chk("stat_conflict", 32'(b1.stat_conflict), 32'd3);
`endif
    next_cycle();

    // LAT=3: simultaneous stores from reset, cpu first; requester changes after grant ignored
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin
        b3.cpu_req = 1'b1;  b3.cpu_wr = 1'b1;  b3.cpu_addr = 32'h40;  b3.cpu_wd = 32'h11111111;  b3.cpu_op = OP_W;
        b3.ext_req = 1'b1;  b3.ext_wr = 1'b1;  b3.ext_addr = 32'h44;  b3.ext_wd = 32'h22222222;  b3.ext_op = OP_W;
      end
      if (c == 1) begin
        b3.cpu_addr = 32'h80;  b3.cpu_wd = 32'hBADBAD00;
      end
      if (c == 3) b3.cpu_req = 1'b0;
      if (c == 6) b3.ext_req = 1'b0;
      @(negedge clk);
      chk($sformatf("t2_c%0d_cpu_done", c), 32'(b3.cpu_done), 32'(t2[c].cd));
      chk($sformatf("t2_c%0d_cpu_stall", c), 32'(b3.cpu_stall), 32'(t2[c].st));
      chk($sformatf("t2_c%0d_ext_done", c), 32'(b3.ext_done), 32'(t2[c].ed));
      chk($sformatf("t2_c%0d_dm_wr", c), 32'(b3.dm_wr), 32'(t2[c].wr));
      chk($sformatf("t2_c%0d_dm_A", c), b3.dm_A, t2[c].a);
      next_cycle();
    end
    chk("t2_mem_cpu", mem3[16], 32'h11111111);
    chk("t2_mem_ext", mem3[17], 32'h22222222);
    chk("t2_mem_ignored", mem3[32], 32'h0);

    // LAT=3: reset asserted in the middle of an ext store
    b3.ext_req = 1'b1;  b3.ext_wr = 1'b1;  b3.ext_addr = 32'h48;  b3.ext_wd = 32'h33333333;  b3.ext_op = OP_W;
    @(negedge clk);
    chk("t6_c0_dm_wr", 32'(b3.dm_wr), 32'd0);
    next_cycle();
    rst3_n = 1'b0;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t6_c%0d_dm_wr", c), 32'(b3.dm_wr), 32'd0);
      chk($sformatf("t6_c%0d_ext_done", c), 32'(b3.ext_done), 32'd0);
      next_cycle();
    end
    b3.ext_req = 1'b0;
    rst3_n = 1'b1;
    @(negedge clk);
    chk("t6_idle_dm_A", b3.dm_A, 32'd0);
    chk("t6_idle_ext_done", 32'(b3.ext_done), 32'd0);
    chk("t6_mem_untouched", mem3[18], 32'h0);
    next_cycle();

    // LAT=3: both requesting continuously must alternate cpu,ext,...
    b3.cpu_req = 1'b1;  b3.cpu_wr = 1'b0;  b3.cpu_addr = 32'h40;  b3.cpu_op = OP_W;
    b3.ext_req = 1'b1;  b3.ext_wr = 1'b0;  b3.ext_addr = 32'h44;  b3.ext_op = OP_W;
    n_got = 0;
    for (int c = 0; c < 60 && n_got < 8; c++) begin
      @(negedge clk);
      if (b3.cpu_done && b3.ext_done) chk("t3_double_done", 32'd1, 32'd0);
      if (b3.cpu_done) begin
        got_side[n_got] = 0;
        chk($sformatf("t3_a%0d_cpu_rd", n_got), b3.cpu_rd, 32'h11111111);
        n_got++;
      end else if (b3.ext_done) begin
        got_side[n_got] = 1;
        chk($sformatf("t3_a%0d_ext_rd", n_got), b3.ext_rd, 32'h22222222);
        n_got++;
      end
      next_cycle();
    end
    chk("t3_count", 32'(n_got), 32'd8);
    for (int k = 0; k < n_got; k++)
      chk($sformatf("t3_a%0d_side", k), 32'(got_side[k]), 32'(k % 2));
    b3.cpu_req = 1'b0;  b3.ext_req = 1'b0;
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
